// File: rtl/pe_vec_mac_if.sv
// Operand/result handshake bundle for the vector MAC processing element.
// The master side (producer/consumer) drives tile control, operand beats and
// out_ready; the slave side (the PE) returns flow control and the tile result.
interface pe_vec_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LANES      = 4,
    parameter int K_WIDTH    = 16
);
    logic                        clear;
    logic                        start;
    logic [K_WIDTH-1:0]          k_len;
    logic [DATA_WIDTH-1:0]       a_zp;
    logic [DATA_WIDTH-1:0]       b_zp;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] a_vec;
    logic [LANES*DATA_WIDTH-1:0] b_vec;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_WIDTH-1:0]        out_acc;
    logic                        out_sat;
    logic                        busy;

    modport master (
        output clear, start, k_len, a_zp, b_zp, in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, busy
    );

    modport slave (
        input  clear, start, k_len, a_zp, b_zp, in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_acc, out_sat, busy
    );
endinterface

// File: rtl/pe_vec_mac.sv
// Multi-lane quantized multiply-accumulate PE. A tile of k_len beats is
// zero-point corrected, reduced across lanes into a stage-1 register, then
// accumulated (optionally saturating). The final value lands in a one-entry
// output register so the next tile can start while the result waits.
module pe_vec_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LANES      = 4,
    parameter int K_WIDTH    = 16,
    parameter bit SATURATE   = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    pe_vec_mac_if.slave bus
);
    localparam int DIFF_W = DATA_WIDTH + 1;
    localparam int PROD_W = 2 * DATA_WIDTH + 2;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [K_WIDTH-1:0]          k_len_q, k_len_d;
    logic [K_WIDTH-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       a_zp_q, a_zp_d;
    logic [DATA_WIDTH-1:0]       b_zp_q, b_zp_d;
    logic signed [ACC_WIDTH-1:0] s1_q, s1_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sat_q, sat_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
    logic                        out_sat_q, out_sat_d;

    logic signed [PROD_W-1:0]    prod [LANES];
    logic signed [SUM_W-1:0]     lane_sum;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] acc_step;
    logic                        acc_ovf;
    logic                        beat_hs;
    logic                        push;
    logic                        last_beat;

    // Per-lane zero-point correction and product. Operands get one extra bit
    // so (a - zp) never overflows; the product is exact at 2*DATA_WIDTH+2.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0]    a_raw;
        logic [DATA_WIDTH-1:0]    b_raw;
        logic signed [DIFF_W-1:0] a_diff;
        logic signed [DIFF_W-1:0] b_diff;

        assign a_raw    = bus.a_vec[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_raw    = bus.b_vec[gi*DATA_WIDTH +: DATA_WIDTH];
        assign a_diff   = $signed({a_raw[DATA_WIDTH-1], a_raw})
                        - $signed({a_zp_q[DATA_WIDTH-1], a_zp_q});
        assign b_diff   = $signed({b_raw[DATA_WIDTH-1], b_raw})
                        - $signed({b_zp_q[DATA_WIDTH-1], b_zp_q});
        assign prod[gi] = PROD_W'(a_diff) * PROD_W'(b_diff);
    end

    // Full-width reduction of the lane products; cannot overflow SUM_W.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(prod[i]);
        end
    end

    // Accumulator adder with signed-overflow detection and optional clamp.
    always_comb begin
        acc_sum  = acc_q + s1_q;
        acc_ovf  = (acc_q[ACC_WIDTH-1] == s1_q[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        acc_step = acc_sum;
        if (acc_ovf && SATURATE) begin
            acc_step = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // A beat is taken only in RUN; a concurrent clear rejects it.
    assign beat_hs   = (state_q == ST_RUN) && bus.in_valid && !bus.clear;
    assign last_beat = (cnt_q + K_WIDTH'(1)) == k_len_q;
    // The result moves out when the output register is empty or being drained.
    assign push      = (state_q == ST_PUSH) && !bus.clear &&
                       (!out_valid_q || bus.out_ready);

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        cnt_d       = cnt_q;
        a_zp_d      = a_zp_q;
        b_zp_d      = b_zp_q;
        s1_d        = s1_q;
        s1_valid_d  = 1'b0;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;

        // Output register: refill wins over drain in the same cycle.
        if (push) begin
            out_valid_d = 1'b1;
            out_acc_d   = acc_q;
            out_sat_d   = sat_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Stage 2: bubbles leave the accumulator untouched.
        if (s1_valid_q) begin
            acc_d = acc_step;
            sat_d = sat_q | acc_ovf;
        end

        // Stage 1: capture the lane sum of an accepted beat.
        if (beat_hs) begin
            s1_d       = ACC_WIDTH'(lane_sum);
            s1_valid_d = 1'b1;
            cnt_d      = cnt_q + K_WIDTH'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.clear) begin
                    k_len_d = bus.k_len;
                    a_zp_d  = bus.a_zp;
                    b_zp_d  = bus.b_zp;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (bus.k_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_hs && last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (push) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort flushes the tile pipeline but never the output register.
        if (bus.clear) begin
            state_d    = ST_IDLE;
            s1_valid_d = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
            sat_d      = 1'b0;
        end
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            cnt_q       <= '0;
            a_zp_q      <= '0;
            b_zp_q      <= '0;
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            cnt_q       <= cnt_d;
            a_zp_q      <= a_zp_d;
            b_zp_q      <= b_zp_d;
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_RUN);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: doc/pe_vec_mac.md
# pe_vec_mac

Multi-lane quantized multiply-accumulate processing element for the NPU outer-product stage, successor to the scalar enable-gated PE. Each tile consumes `k_len` beats of `LANES` signed operand pairs, subtracts per-tile zero points, and accumulates the lane dot-product through a two-stage pipeline. The accumulator is optionally saturating. The finished tile result is delivered through a one-entry valid/ready output register, so the next tile can accumulate while the previous result waits.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: signed operand width.
- `ACC_WIDTH`, 24: signed accumulator/result width. Must be ≥ 2*DATA_WIDTH+2+clog2(LANES).
- `LANES`, 4: operand pairs per beat.
- `K_WIDTH`, 16: width of the beat counter and `k_len`.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

**Ports**
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the current tile.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  K_WIDTH  beats in the tile; latched on start.
- `a_zp`, `b_zp`  in  DATA_WIDTH  signed zero points; latched on start.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `a_vec`, `b_vec`  in  LANES*DATA_WIDTH  packed signed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_valid`  out  1  result register full.
- `out_ready`  in  1  consumer accepts result.
- `out_acc`  out  ACC_WIDTH  tile result.
- `out_sat`  out  1  overflow occurred during this tile.
- `busy`  out  1  state ≠ IDLE.

## Operation

**Arithmetic**
- Per lane: (a − a_zp) × (b − b_zp), with operands extended to DATA_WIDTH+1 bits and the product 2*DATA_WIDTH+2 bits.
- Lane products are summed at full width and sign-extended to ACC_WIDTH.
- Accumulate: `acc_next = acc + s1`.
  - On signed overflow, SATURATE=1 clamps to +max or −min; SATURATE=0 wraps.
  - In both modes, overflow sets a sticky per-tile sat bit.

**States**
- IDLE
  - On `start` (and no `clear`): latch `k_len` and zero points, zero the accumulator, sat bit and beat counter.
  - Go to RUN; if `k_len` = 0, go to DRAIN instead.
- RUN
  - `in_ready` = 1.
  - Each handshake loads the stage-1 register (the lane sum) and increments the counter.
  - When the counter reaches `k_len` on a handshake, go to DRAIN.
  - `in_valid` gaps insert bubbles; a stage-1 bubble does not modify the accumulator.
- DRAIN (1 cycle)
  - The last stage-1 value is accumulated.
  - Go to PUSH.
- PUSH
  - If `out_valid` = 0, or `out_ready` = 1 this cycle: copy acc/sat into `out_acc`/`out_sat`, set `out_valid`, go to IDLE.
  - Otherwise stay in PUSH with `in_ready` = 0.
- Output register
  - `out_valid` clears on `out_ready` unless refilled the same cycle.
  - `out_acc` is held stable while `out_valid & !out_ready`.
- `start` outside IDLE is ignored. `start` in IDLE while `out_valid` = 1 is allowed (overlapped tile).
- `clear`
  - Returns to IDLE and flushes stage-1, the accumulator, the counter and the sat bit.
  - Does not touch `out_valid`, `out_acc` or `out_sat`.
  - Beats presented in the same cycle are not accepted.
  - Takes priority over `start`.
- `rst_n` low, at any time: immediately IDLE.
  - All registers return to 0: `in_ready` = 0, `out_valid` = 0, `out_acc` = 0, `out_sat` = 0, `busy` = 0.

## Timing
- `in_ready` is a registered state decode and does not depend combinationally on `in_valid`.
- `out_valid` and `out_acc` are registered.
- Start to first acceptable beat: `in_ready` goes high in the cycle after the `start` cycle.
- Last-beat handshake in cycle T:
  - Stage-1 is valid in T+1.
  - Accumulation happens in T+1 (DRAIN).
  - PUSH is in T+2.
  - With a free output register, `out_valid` is high from T+3.
- Throughput: one beat per cycle in RUN. Per-tile overhead is 3 cycles (start, DRAIN, PUSH) with a free output.
- `k_len` = 0: `start` in cycle S leads to DRAIN in S+1, PUSH in S+2, and `out_valid` with `out_acc` = 0 in S+3.
- Release of `rst_n` is assumed synchronised externally. The first edge after release sees IDLE.

## Test plan
- Basic tile: LANES = 4, zp = 0, k_len = 3, all a = 3 and b = 2, continuous `in_valid`, `out_ready` = 1 → `out_acc` = 72, `out_sat` = 0, `out_valid` 3 cycles after the last handshake.
- Zero points and signs, k_len = 2:
  - Setup: a_zp = 5, b_zp = −3.
  - Beat 1: a lanes {5, 6, 4, 15}, b lanes {−3, −1, 1, 0}.
  - Beat 2: all a = 5.
  - Expect `out_acc` = 0+2−4+30+0 = 28.
- Saturation, k_len = 40, a = b = 127, a_zp = b_zp = −128 (255 × 255 × 4 = 260100 per beat):
  - SATURATE=1 → `out_acc` = 8388607, `out_sat` = 1.
  - SATURATE=0 → `out_acc` = 10404000 − 2^24 = −6373216, `out_sat` = 1.
- Backpressure and overlap:
  - Tile A (result 72) done with `out_ready` = 0. Tile B (k = 1, result 24) runs, then holds in PUSH with `in_ready` = 0.
  - Raise `out_ready` for 1 cycle → A transferred, B loaded the same cycle; `out_acc` = 24 with `out_valid` still high.
- `in_valid` gaps plus k_len = 0: random bubbles in the basic tile → still 72. k_len = 0 → `out_acc` = 0 three cycles after `start`.
- Abort and reset:
  - `clear` after 2 of 3 beats with a pending output → pending result unchanged, next tile result correct (no stale accumulation).
  - `rst_n` low mid-RUN → all outputs 0 asynchronously; IDLE on release.
